// File: rtl/adc128s022_scanner_if.sv
// Control, SPI pin and result-stream bundle for adc128s022_scanner.
// master = scanner side, slave = consumer / board side.
interface adc128s022_scanner_if;
   logic        enable;
   logic [7:0]  chan_mask;
   logic        ADC_CS_N;
   logic        ADC_SCLK;
   logic        ADC_SADDR;
   logic        ADC_SDAT;
   logic        busy;
   logic        sample_valid;
   logic [2:0]  sample_chan;
   logic [11:0] sample_data;
   logic        frame_err;

   modport master (
      input  enable, chan_mask, ADC_SDAT,
      output ADC_CS_N, ADC_SCLK, ADC_SADDR, busy,
             sample_valid, sample_chan, sample_data, frame_err
   );

   modport slave (
      output enable, chan_mask, ADC_SDAT,
      input  ADC_CS_N, ADC_SCLK, ADC_SADDR, busy,
             sample_valid, sample_chan, sample_data, frame_err
   );
endinterface

// File: rtl/adc128s022_scanner.sv
// Round-robin SPI scanner for the ADC128S022; results lag the sent address by one frame.
// Define ADC128S022_ZERO_CHECK_EN to flag frames whose four leading bits are not zero.
module adc128s022_scanner #(
   parameter int unsigned CLK_DIV_HALF = 8,
   parameter int unsigned CS_GAP       = 4
) (
   input  logic                        CLOCK_50,
   input  logic                        reset,
   adc128s022_scanner_if.master        bus
);
   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

   localparam logic [7:0] HALF_LAST = 8'(CLK_DIV_HALF - 1);
   localparam logic [7:0] GAP_LAST  = 8'(CS_GAP - 1);
`ifdef ADC128S022_ZERO_CHECK_EN
   localparam int unsigned RX_W = 16;
`else
   localparam int unsigned RX_W = 12;
`endif

   state_t            r_state, w_state_nxt;
   logic [7:0]        r_cnt;
   logic              r_phase_hi;
   logic [3:0]        r_bit;
   logic [2:0]        r_ptr, r_cur_addr, r_prev_addr;
   logic              r_prime;
   logic [15:0]       r_tx;
   logic [RX_W-1:0]   r_rx;
   logic              r_cs_n, r_sclk, r_saddr, r_busy, r_valid;
   logic [2:0]        r_chan;
   logic [11:0]       r_data;

   logic              w_run, w_half_done, w_gap_done;
   logic              w_start, w_from_idle, w_fall, w_rise, w_end;
   logic [2:0]        w_addr, w_idx;
   logic              w_found;

   assign w_run       = bus.enable && (bus.chan_mask != '0);
   assign w_half_done = (r_cnt == HALF_LAST);
   assign w_gap_done  = (r_cnt == GAP_LAST);

   // Next enabled channel after the pointer, wrapping 7 -> 0.
   always_comb begin
      w_addr  = r_ptr;
      w_found = 1'b0;
      w_idx   = r_ptr;
      for (int unsigned i = 1; i <= 8; i++) begin
         w_idx = r_ptr + 3'(i);
         if (!w_found && bus.chan_mask[w_idx]) begin
            w_addr  = w_idx;
            w_found = 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_from_idle = 1'b0;
      w_fall      = 1'b0;
      w_rise      = 1'b0;
      w_end       = 1'b0;
      unique case (r_state)
         IDLE:
            if (w_run) begin
               w_state_nxt = SETUP;
               w_start     = 1'b1;
               w_from_idle = 1'b1;
            end
         SETUP:
            if (w_half_done) begin
               w_state_nxt = SHIFT;
               w_fall      = 1'b1;
            end
         SHIFT:
            if (w_half_done) begin
               if (!r_phase_hi) begin
                  w_rise = 1'b1;
               end else if (r_bit == 4'd15) begin
                  w_state_nxt = GAP;
                  w_end       = 1'b1;
               end else begin
                  w_fall = 1'b1;
               end
            end
         GAP:
            if (w_gap_done) begin
               if (w_run) begin
                  w_state_nxt = SETUP;
                  w_start     = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_cnt       <= '0;
         r_phase_hi  <= 1'b1;
         r_bit       <= '0;
         r_ptr       <= 3'd7;
         r_cur_addr  <= '0;
         r_prev_addr <= '0;
         r_prime     <= 1'b0;
         r_tx        <= '0;
         r_rx        <= '0;
         r_cs_n      <= 1'b1;
         r_sclk      <= 1'b1;
         r_saddr     <= 1'b0;
         r_busy      <= 1'b0;
         r_valid     <= 1'b0;
         r_chan      <= '0;
         r_data      <= '0;
      end else begin
         r_valid <= 1'b0;
         r_busy  <= (w_state_nxt != IDLE);
         r_cnt   <= (r_state == IDLE || w_start || w_fall || w_rise || w_end) ? '0 : r_cnt + 8'd1;
         if (w_start) begin
            r_cs_n     <= 1'b0;
            r_ptr      <= w_addr;
            r_cur_addr <= w_addr;
            r_tx       <= {2'b00, w_addr, 11'b0};
            if (w_from_idle) r_prime <= 1'b1;
         end
         if (w_fall) begin
            r_sclk     <= 1'b0;
            r_saddr    <= r_tx[15];
            r_tx       <= {r_tx[14:0], 1'b0};
            r_phase_hi <= 1'b0;
            r_bit      <= (r_state == SETUP) ? '0 : r_bit + 4'd1;
         end
         if (w_rise) begin
            r_sclk     <= 1'b1;
            r_rx       <= {r_rx[RX_W-2:0], bus.ADC_SDAT};
            r_phase_hi <= 1'b1;
         end
         // rx holds the conversion for the address sent one frame earlier.
         if (w_end) begin
            r_cs_n      <= 1'b1;
            r_saddr     <= 1'b0;
            r_prev_addr <= r_cur_addr;
            if (r_prime) begin
               r_prime <= 1'b0;
            end else begin
               r_valid <= 1'b1;
               r_data  <= r_rx[11:0];
               r_chan  <= r_prev_addr;
            end
         end
      end
   end

`ifdef ADC128S022_ZERO_CHECK_EN
   logic r_err;
   always_ff @(posedge CLOCK_50) begin
      if (reset) r_err <= 1'b0;
      else       r_err <= w_end && !r_prime && (r_rx[15:12] != 4'd0);
   end
   assign bus.frame_err = r_err;
`else
   assign bus.frame_err = 1'b0;
`endif

   assign bus.ADC_CS_N     = r_cs_n;
   assign bus.ADC_SCLK     = r_sclk;
   assign bus.ADC_SADDR    = r_saddr;
   assign bus.busy         = r_busy;
   assign bus.sample_valid = r_valid;
   assign bus.sample_chan  = r_chan;
   assign bus.sample_data  = r_data;
endmodule

// File: doc/adc128s022_scanner.md
Name: adc128s022_scanner

Overview:
- Synthesizable SPI initiator for the on-board ADC128S022 (8-channel, 12-bit). It owns the ADC_CS_N, ADC_SCLK, ADC_SADDR and ADC_SDAT nets.
- Continuously round-robin scans the channels enabled in a mask. Each completed conversion is presented as a one-cycle result strobe tagged with its channel.
- Sits directly below the top level and feeds any consumer of analog readings (LED bar display, logging).

Parameters:
- CLK_DIV_HALF, 8, CLOCK_50 cycles per SCLK half-period. Legal range 8..31; 8 gives SCLK = 3.125 MHz.
- CS_GAP, 4, CLOCK_50 cycles ADC_CS_N is held high between frames. Legal range 1..255.

Ports:
- CLOCK_50  in  1  50 MHz system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  scan run request, level-sensitive
- chan_mask  in  8  bit i = 1 includes channel i in the scan; sampled at frame start
- ADC_CS_N  out  1  ADC chip select, active-low
- ADC_SCLK  out  1  ADC serial clock; idles high
- ADC_SADDR  out  1  control word to ADC (DIN)
- ADC_SDAT  in  1  conversion data from ADC (DOUT)
- busy  out  1  high while not in IDLE
- sample_valid  out  1  one-cycle result strobe
- sample_chan  out  3  channel of the current result
- sample_data  out  12  conversion result, unsigned
- frame_err  out  1  one-cycle leading-zero error strobe (optional feature)

Behaviour:
- One clock (CLOCK_50); reset is synchronous and active-high. All outputs are registered.
- Reset values: ADC_CS_N=1, ADC_SCLK=1, ADC_SADDR=0, busy=0, sample_valid=0, sample_chan=0, sample_data=0, frame_err=0. State goes to IDLE; the round-robin pointer goes to 7, so the first selected channel is the lowest set bit of chan_mask.
- FSM states are IDLE, SETUP, SHIFT and GAP.
- IDLE:
  - CS_N=1, SCLK=1.
  - If enable=1 and chan_mask!=0, go to SETUP with the prime flag set.
- SETUP (CLK_DIV_HALF cycles):
  - CS_N=0, SCLK=1.
  - Compute addr = the next set bit of chan_mask after the pointer, wrapping 7->0. Update the pointer.
  - Load the 16-bit shift word {2'b00, addr, 11'b0}, MSB first.
- SHIFT: 16 bit-periods, each made of a low phase of CLK_DIV_HALF cycles then a high phase of CLK_DIV_HALF cycles.
  - At each SCLK falling edge, ADC_SADDR presents the next control bit. The ADC samples it on the following rising edge.
  - At each SCLK rising edge, ADC_SDAT is shifted into a 16-bit receive register.
  - After the 16th high phase, go to GAP.
- GAP (CS_GAP cycles):
  - ADC_CS_N=1 on the first GAP cycle.
  - In that same first cycle, if the prime flag is clear: sample_valid=1, sample_data=rx[11:0], sample_chan=the address sent in the previous frame.
  - If the prime flag is set, no strobe is generated and the prime flag is cleared.
  - At the end of GAP: go to SETUP if enable=1 and chan_mask!=0, otherwise go to IDLE.
- Pipelining: the result of frame N belongs to the address sent in frame N-1. A previous-address register holds this; leaving IDLE always costs one discarded prime frame.
- Timing: CS_N is low for 33*CLK_DIV_HALF cycles. The frame period is 33*CLK_DIV_HALF + CS_GAP cycles (268 at the defaults).
- enable deasserted mid-frame: the frame completes and its result is delivered, then the FSM goes to IDLE. The previous-address register and the pointer are kept across IDLE.
- chan_mask changes mid-frame: no effect until the next SETUP. The mask becoming 0 is equivalent to enable=0.
- Single-bit mask: the same channel is converted every frame.
- reset asserted mid-frame: on the next clock edge, all outputs take their reset values and the FSM goes to IDLE. No strobe is generated for the aborted frame.

Optional Feature:
- Macro ADC128S022_ZERO_CHECK_EN.
- Defined:
  - In the first GAP cycle of a non-prime frame, frame_err=1 for one cycle if rx[15:12]!=0.
  - sample_valid is still asserted with data.
- Undefined: frame_err is tied to 0 and rx[15:12] is not checked.

Test Plan:
1. Reset, then enable=1, mask=8'h01, ADC model returning 0x0ABC:
   - First frame produces no strobe.
   - Strobes follow every 268 cycles with chan=0 and data=0xABC.
   - SCLK period is 16 cycles.
2. mask=8'hA4, model returns 0x100*ch+ch:
   - SADDR address sequence is 2,5,7,2,5.
   - Strobe tags are 2,5,7,2 with matching data.
3. ADC model checks DIN on the rising edge and DOUT on the falling edge:
   - Zero protocol violations over 20 frames.
   - CS_N low for 264 cycles per frame.
4. enable dropped at bit 5 of frame 3:
   - Frame 3 result is delivered.
   - The FSM then goes to IDLE with busy=0, CS_N=1, SCLK=1 held.
5. reset pulsed mid-SHIFT:
   - The next cycle shows CS_N=1, SCLK=1, sample_valid=0.
   - Re-enabling starts a new prime frame.
6. With ADC128S022_ZERO_CHECK_EN defined, model drives leading bits 4'b0010: frame_err and sample_valid pulse together. Without the macro, frame_err stays 0.
